line_index_serializer: RTL and testbench
========================================

Name: line_index_serializer

Overview:
- Downstream consumer of the 64-line combinational display decoder output.
- Snapshots the 64-bit line vector on a load strobe.
- Emits the index of every asserted line, lowest index first, one index per valid/ready handshake.
- Reports count and completion so the next display-drive stage can walk active lines serially instead of fanning out 64 wires.

Parameters:
- N_LINES, 64, width of the line vector from the decoder.
- IDX_W, 6, index width; must equal clog2(N_LINES).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- lines_i  input  N_LINES  decoded line vector (bit k = line k active).
- load_i  input  1  snapshot strobe; sampled every cycle.
- idx_o  output  IDX_W  index of the lowest pending line.
- idx_valid_o  output  1  idx_o valid.
- idx_ready_i  input  1  downstream accepts idx_o.
- last_o  output  1  current idx_o is the final pending line; qualified by idx_valid_o.
- count_o  output  IDX_W+1  indices accepted since the last load; range 0..64.
- done_o  output  1  one-cycle pulse when a snapshot is fully drained, or was empty.
- busy_o  output  1  high in SCAN.
- overrun_o  output  1  sticky; set when load_i arrives while busy.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, pending mask=0, count_o=0.
  - idx_valid_o=0, done_o=0, busy_o=0, overrun_o=0; idx_o=0, last_o=0.
  - Reset overrides every other input in the same cycle.
  - Reset mid-SCAN abandons the snapshot; no done_o is generated.
- States: IDLE, SCAN.
- IDLE, load_i=1 at edge t:
  - pending <= lines_i and count_o <= 0.
  - If lines_i != 0: state <= SCAN, so idx_valid_o=1 from cycle t+1. Load-to-first-valid latency is 1 cycle.
  - If lines_i == 0: stay IDLE and pulse done_o in cycle t+1, with count_o=0.
- SCAN outputs:
  - idx_o = position of the lowest set bit of pending, from a combinational priority encoder on the registered mask.
  - idx_valid_o=1, busy_o=1.
  - last_o=1 when pending has exactly one bit set.
- Handshake:
  - A transfer occurs when idx_valid_o and idx_ready_i are both high at an edge.
  - idx_o and last_o hold stable while idx_ready_i=0.
  - On a transfer: clear that bit in pending and count_o <= count_o+1.
  - If the transfer had last_o=1: state <= IDLE and done_o pulses in the next cycle, alongside idx_valid_o=0.
  - One index per cycle maximum; with ready held high, K set bits drain in K cycles.
- load_i in SCAN:
  - Ignored; pending is unchanged.
  - overrun_o <= 1 and stays set until rst.
- load_i in the cycle done_o is high: state is already IDLE, so the load is accepted normally.
- count_o holds its final value in IDLE until the next accepted load.
- Width rules:
  - count_o is IDX_W+1 bits so a full 64-line snapshot reports 64 (7'd64) without wrap.
  - idx_o never exceeds N_LINES-1.

Decomposition:
- Package display_pkg holds:
  - constants N_LINES=64 and IDX_W=6;
  - typedef line_vec_t (logic [N_LINES-1:0]) and line_idx_t (logic [IDX_W-1:0]);
  - enum ser_state_t {IDLE, SCAN}.
- Sub-module prio_enc_lowest: purely combinational.
  - Input: line_vec_t.
  - Outputs: line_idx_t of the lowest set bit, plus any_o and onehot_o flags (onehot_o drives last_o).

Test Plan:
- Three lines: load 64'h2000_4000_0000_0008 with ready=1 -> idx_o sequence 3, 46, 61 on consecutive cycles; last_o only with 61; done_o pulse the next cycle; count_o=3.
- Empty snapshot: load 64'h0 -> idx_valid_o never rises; done_o pulses the cycle after load; count_o=0; busy_o stays 0.
- Backpressure: load 64'h8000_0000_0000_0001, ready=0 for 5 cycles -> idx_o=0 held stable with valid=1; then ready=1 gives idx 0, then 63 with last_o=1.
- Full vector: load all-ones with ready=1 -> 64 consecutive indices 0..63; count_o=64; done_o once.
- Overrun and reset: a load during SCAN leaves the stream unchanged and sets overrun_o=1. rst mid-SCAN then gives IDLE, idx_valid_o=0, overrun_o=0 and no done_o on the following cycle.
- Back-to-back: load asserted in the same cycle as done_o is accepted; the new snapshot's first index is valid one cycle later.

Source files
------------

// File: rtl/line_index_serializer_pkg.sv
// Shared types for the display line serializer: line vector, line index and FSM state.
package display_pkg;

  localparam int N_LINES = 64;
  localparam int IDX_W   = 6;

  typedef logic [N_LINES-1:0] line_vec_t;
  typedef logic [IDX_W-1:0]   line_idx_t;
  typedef logic [IDX_W:0]     line_cnt_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } ser_state_t;

endpackage

// File: rtl/line_index_serializer_prio.sv
// Combinational lowest-set-bit encoder with any / exactly-one flags.
import display_pkg::*;

module prio_enc_lowest (
  input  line_vec_t i_vec,
  output line_idx_t o_idx,
  output logic      o_any,
  output logic      o_onehot
);

  line_vec_t w_low_clr;

  // Scan high to low so the lowest set bit is the last to write o_idx.
  always_comb begin
    o_idx = '0;
    for (int k = N_LINES - 1; k >= 0; k--) begin
      if (i_vec[k]) o_idx = line_idx_t'(k);
    end
  end

  assign w_low_clr = i_vec & (i_vec - line_vec_t'(1));
  assign o_any     = |i_vec;
  assign o_onehot  = o_any && (w_low_clr == '0);

endmodule

// File: rtl/line_index_serializer.sv
// Snapshots a decoded line vector and streams the index of each active line, lowest first.
import display_pkg::*;

module line_index_serializer (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_LINES-1:0] lines_i,
  input  logic              load_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              idx_valid_o,
  input  logic              idx_ready_i,
  output logic              last_o,
  output logic [IDX_W:0]    count_o,
  output logic              done_o,
  output logic              busy_o,
  output logic              overrun_o
);

  ser_state_t r_state;
  line_vec_t  r_pend;
  line_cnt_t  r_count;
  logic       r_done;
  logic       r_overrun;

  line_idx_t  w_idx;
  logic       w_any;
  logic       w_onehot;
  logic       w_xfer;
  line_vec_t  w_pend_next;

  prio_enc_lowest u_enc (
    .i_vec    (r_pend),
    .o_idx    (w_idx),
    .o_any    (w_any),
    .o_onehot (w_onehot)
  );

  assign w_xfer      = (r_state == SCAN) && idx_ready_i;
  // Clearing the lowest set bit is the same bit the encoder is presenting.
  assign w_pend_next = r_pend & (r_pend - line_vec_t'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pend    <= '0;
      r_count   <= '0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load_i) begin
            r_pend  <= lines_i;
            r_count <= '0;
            if (|lines_i) r_state <= SCAN;
            else          r_done  <= 1'b1;
          end
        end
        SCAN: begin
          if (load_i) r_overrun <= 1'b1;
          if (w_xfer) begin
            r_pend  <= w_pend_next;
            r_count <= r_count + line_cnt_t'(1);
            if (w_onehot) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign idx_o       = w_idx;
  assign idx_valid_o = (r_state == SCAN);
  assign busy_o      = (r_state == SCAN);
  assign last_o      = (r_state == SCAN) && w_onehot;
  assign count_o     = r_count;
  assign done_o      = r_done;
  assign overrun_o   = r_overrun;

  logic w_unused;
  assign w_unused = w_any;

endmodule

// File: tb/tb_line_index_serializer.sv
// Directed bench for line_index_serializer with hand-computed expectations.
module tb_line_index_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] lines_i;
  logic        load_i;
  logic [5:0]  idx_o;
  logic        idx_valid_o;
  logic        idx_ready_i;
  logic        last_o;
  logic [6:0]  count_o;
  logic        done_o;
  logic        busy_o;
  logic        overrun_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  line_index_serializer dut (
    .clk         (clk),
    .rst         (rst),
    .lines_i     (lines_i),
    .load_i      (load_i),
    .idx_o       (idx_o),
    .idx_valid_o (idx_valid_o),
    .idx_ready_i (idx_ready_i),
    .last_o      (last_o),
    .count_o     (count_o),
    .done_o      (done_o),
    .busy_o      (busy_o),
    .overrun_o   (overrun_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [5:0] idx,
                         input logic l, input logic [6:0] cnt, input logic d, input logic b);
    chk({tag, ".valid"}, idx_valid_o, v);
    if (v) chk({tag, ".idx"}, idx_o, idx);
    chk({tag, ".last"}, last_o, l);
    chk({tag, ".count"}, count_o, cnt);
    chk({tag, ".done"}, done_o, d);
    chk({tag, ".busy"}, busy_o, b);
  endtask

  initial begin
    rst = 1'b1; load_i = 1'b0; idx_ready_i = 1'b0; lines_i = '0;
    step(); step();
    rst = 1'b0;
    chk_out("reset", 1'b0, 6'd0, 1'b0, 7'd0, 1'b0, 1'b0);
    chk("reset.idx", idx_o, 64'd0);
    chk("reset.overrun", overrun_o, 64'd0);

    // Three lines: 3, 46, 61
    lines_i = 64'h2000_4000_0000_0008; load_i = 1'b1; idx_ready_i = 1'b1;
    step(); load_i = 1'b0;
    chk_out("three0", 1'b1, 6'd3,  1'b0, 7'd0, 1'b0, 1'b1); step();
    chk_out("three1", 1'b1, 6'd46, 1'b0, 7'd1, 1'b0, 1'b1); step();
    chk_out("three2", 1'b1, 6'd61, 1'b1, 7'd2, 1'b0, 1'b1); step();
    chk_out("three_done", 1'b0, 6'd0, 1'b0, 7'd3, 1'b1, 1'b0); step();
    chk_out("three_hold", 1'b0, 6'd0, 1'b0, 7'd3, 1'b0, 1'b0);

    // Empty snapshot
    lines_i = 64'h0; load_i = 1'b1;
    step(); load_i = 1'b0;
    chk_out("empty_done", 1'b0, 6'd0, 1'b0, 7'd0, 1'b1, 1'b0); step();
    chk_out("empty_after", 1'b0, 6'd0, 1'b0, 7'd0, 1'b0, 1'b0);

    // Backpressure: bits 0 and 63
    lines_i = 64'h8000_0000_0000_0001; load_i = 1'b1; idx_ready_i = 1'b0;
    step(); load_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_out($sformatf("bp_hold%0d", i), 1'b1, 6'd0, 1'b0, 7'd0, 1'b0, 1'b1);
      if (i < 4) step();
    end
    idx_ready_i = 1'b1;
    step();
    chk_out("bp_63", 1'b1, 6'd63, 1'b1, 7'd1, 1'b0, 1'b1); step();
    chk_out("bp_done", 1'b0, 6'd0, 1'b0, 7'd2, 1'b1, 1'b0);

    // Full vector
    lines_i = '1; load_i = 1'b1;
    step(); load_i = 1'b0;
    for (int i = 0; i < 64; i++) begin
      chk_out($sformatf("full%0d", i), 1'b1, 6'(i), (i == 63), 7'(i), 1'b0, 1'b1);
      step();
    end
    chk_out("full_done", 1'b0, 6'd0, 1'b0, 7'd64, 1'b1, 1'b0); step();
    chk_out("full_after", 1'b0, 6'd0, 1'b0, 7'd64, 1'b0, 1'b0);

    // Overrun then reset mid-SCAN: bits 1, 2, 4
    lines_i = 64'h16; load_i = 1'b1;
    step();
    chk_out("ovr0", 1'b1, 6'd1, 1'b0, 7'd0, 1'b0, 1'b1);
    chk("ovr0.overrun", overrun_o, 64'd0);
    lines_i = '1;
    step(); load_i = 1'b0;
    chk_out("ovr1", 1'b1, 6'd2, 1'b0, 7'd1, 1'b0, 1'b1);
    chk("ovr1.overrun", overrun_o, 64'd1);
    idx_ready_i = 1'b0; rst = 1'b1;
    step(); rst = 1'b0;
    chk_out("rst_mid", 1'b0, 6'd0, 1'b0, 7'd0, 1'b0, 1'b0);
    chk("rst_mid.overrun", overrun_o, 64'd0);
    step();
    chk_out("rst_after", 1'b0, 6'd0, 1'b0, 7'd0, 1'b0, 1'b0);

    // Back-to-back: load accepted in the done cycle
    lines_i = 64'h5; load_i = 1'b1; idx_ready_i = 1'b1;
    step(); load_i = 1'b0;
    chk_out("b2b0", 1'b1, 6'd0, 1'b0, 7'd0, 1'b0, 1'b1); step();
    chk_out("b2b1", 1'b1, 6'd2, 1'b1, 7'd1, 1'b0, 1'b1); step();
    chk_out("b2b_done", 1'b0, 6'd0, 1'b0, 7'd2, 1'b1, 1'b0);
    lines_i = 64'h10; load_i = 1'b1;
    step(); load_i = 1'b0;
    chk_out("b2b_new", 1'b1, 6'd4, 1'b1, 7'd0, 1'b0, 1'b1); step();
    chk_out("b2b_new_done", 1'b0, 6'd0, 1'b0, 7'd1, 1'b1, 1'b0);
    chk("final.overrun", overrun_o, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
